// File: rtl/jtframe_tilemap_fetch.sv
// Bridges the renderer's fire-and-forget ROM address to an SDRAM cs/ok handshake; rom_cs 1 clk after an address change, tm_ok no earlier than 3 clks.
// No backpressure to the renderer: a slow SDRAM answer times out after TIMEOUT pixel enables and is counted as a miss.
module jtframe_tilemap_fetch #(
  parameter int AW      = 15,
  parameter int DW      = 32,
  parameter int TIMEOUT = 7,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  input  logic [AW-1:0]   tm_addr,
  input  logic            tm_cs,
  output logic [DW-1:0]   tm_data,
  output logic            tm_ok,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cs,
  input  logic            rom_ok,
  input  logic [DW-1:0]   rom_data,
  output logic            miss,
  output logic [CNTW-1:0] miss_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GUARD, WAIT} state_t;

  state_t          state;
  logic            have_last;
  logic [AW-1:0]   last_addr;
  logic [TW-1:0]   timer;
  logic            addr_chg;
  logic            new_req;
  logic [CNTW-1:0] cnt_next;

  assign addr_chg = tm_addr != last_addr;
  assign new_req  = tm_cs & (~have_last | addr_chg);
  assign cnt_next = (&miss_cnt) ? miss_cnt : miss_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      have_last <= 1'b0;
      last_addr <= '0;
      timer     <= '0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      tm_data   <= '0;
      tm_ok     <= 1'b0;
      miss      <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      miss <= 1'b0;
      if (!tm_cs) begin
        // Blanking: drop the request and forget the address so it is refetched later
        rom_cs    <= 1'b0;
        have_last <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (new_req) begin
              rom_addr  <= tm_addr;
              last_addr <= tm_addr;
              have_last <= 1'b1;
              rom_cs    <= 1'b1;
              tm_ok     <= 1'b0;
              timer     <= '0;
              state     <= GUARD;
            end
          end
          GUARD, WAIT: begin
            if (addr_chg) begin
              // Renderer moved on: abandon the fetch and restart without dropping rom_cs
              miss      <= 1'b1;
              miss_cnt  <= cnt_next;
              rom_addr  <= tm_addr;
              last_addr <= tm_addr;
              timer     <= '0;
              state     <= GUARD;
            end else if (state == GUARD) begin
              // rom_ok may still be high from the previous slot, so it is not trusted yet
              state <= WAIT;
            end else if (rom_ok) begin
              tm_data <= rom_data;
              tm_ok   <= 1'b1;
              rom_cs  <= 1'b0;
              state   <= IDLE;
            end else if (pxl_cen) begin
              if (timer == TLAST) begin
                miss     <= 1'b1;
                miss_cnt <= cnt_next;
                rom_cs   <= 1'b0;
                state    <= IDLE;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_tilemap_fetch.sv
// Directed bench for jtframe_tilemap_fetch: a vector table for the basic fetches, hand sequences for timeout, abort, blanking, reset and saturation.
module tb_jtframe_tilemap_fetch;

  logic        clk = 1'b0;
  logic        rst, pxl_cen, tm_cs, rom_ok;
  logic [14:0] tm_addr;
  logic [31:0] rom_data;

  logic [31:0] tm_data, tm_data2;
  logic        tm_ok, tm_ok2, rom_cs, rom_cs2, miss, miss2;
  logic [14:0] rom_addr, rom_addr2;
  logic [7:0]  miss_cnt;
  logic [1:0]  miss_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtframe_tilemap_fetch dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .tm_addr(tm_addr), .tm_cs(tm_cs),
    .tm_data(tm_data), .tm_ok(tm_ok), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_ok(rom_ok), .rom_data(rom_data), .miss(miss), .miss_cnt(miss_cnt)
  );

  jtframe_tilemap_fetch #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .tm_addr(tm_addr), .tm_cs(tm_cs),
    .tm_data(tm_data2), .tm_ok(tm_ok2), .rom_addr(rom_addr2), .rom_cs(rom_cs2),
    .rom_ok(rom_ok), .rom_data(rom_data), .miss(miss2), .miss_cnt(miss_cnt2)
  );

  typedef struct {
    logic        cs;
    logic [14:0] addr;
    logic        ok;
    logic [31:0] data;
    logic        exp_cs;
    logic [14:0] exp_addr;
    logic        exp_ok;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  initial begin
    int first_k, pulses, cs_rise;
    bit seen;
    logic [1:0] exp_sat [5];

    // Fetch 0x0123 with a late ok, then 0x0124 with ok stuck high.
    vt[0] = '{1, 15'h0123, 0, 32'h0,         1, 15'h0123, 0, 32'h0};
    vt[1] = '{1, 15'h0123, 0, 32'h0,         1, 15'h0123, 0, 32'h0};
    vt[2] = '{1, 15'h0123, 0, 32'h0,         1, 15'h0123, 0, 32'h0};
    vt[3] = '{1, 15'h0123, 0, 32'h0,         1, 15'h0123, 0, 32'h0};
    vt[4] = '{1, 15'h0123, 1, 32'hA5A55A5A,  0, 15'h0123, 1, 32'hA5A55A5A};
    vt[5] = '{1, 15'h0124, 1, 32'hA5A55A5A,  1, 15'h0124, 0, 32'hA5A55A5A};
    vt[6] = '{1, 15'h0124, 1, 32'hDEADBEEF,  1, 15'h0124, 0, 32'hA5A55A5A};
    vt[7] = '{1, 15'h0124, 1, 32'h11112222,  0, 15'h0124, 1, 32'h11112222};
    vt[8] = '{1, 15'h0124, 0, 32'h0,         0, 15'h0124, 1, 32'h11112222};
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1; pxl_cen = 0; tm_cs = 0; tm_addr = '0; rom_ok = 0; rom_data = '0;
    step(); step();
    chk("rst rom_cs", {31'b0, rom_cs}, 0);
    chk("rst rom_addr", {17'b0, rom_addr}, 0);
    chk("rst tm_data", tm_data, 0);
    chk("rst tm_ok", {31'b0, tm_ok}, 0);
    chk("rst miss", {31'b0, miss}, 0);
    chk("rst miss_cnt", {24'b0, miss_cnt}, 0);
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      tm_cs = vt[i].cs; tm_addr = vt[i].addr; rom_ok = vt[i].ok; rom_data = vt[i].data;
      step();
      chk($sformatf("vec%0d rom_cs", i), {31'b0, rom_cs}, {31'b0, vt[i].exp_cs});
      chk($sformatf("vec%0d rom_addr", i), {17'b0, rom_addr}, {17'b0, vt[i].exp_addr});
      chk($sformatf("vec%0d tm_ok", i), {31'b0, tm_ok}, {31'b0, vt[i].exp_ok});
      chk($sformatf("vec%0d tm_data", i), tm_data, vt[i].exp_data);
      chk($sformatf("vec%0d miss", i), {31'b0, miss}, 0);
    end
    chk("vec miss_cnt", {24'b0, miss_cnt}, 0);

    // Timeout with pxl_cen every 4 clks: miss on the 7th enable seen in WAIT
    tm_addr = 15'h0200; rom_ok = 0;
    step();
    first_k = -1; pulses = 0; cs_rise = 0;
    for (int k = 0; k < 40; k++) begin
      pxl_cen = (k % 4 == 3);
      step();
      if (miss) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (first_k >= 0 && k > first_k && rom_cs) cs_rise++;
    end
    pxl_cen = 0;
    chk("to miss cycle", first_k, 27);
    chk("to miss pulses", pulses, 1);
    chk("to no retry", cs_rise, 0);
    chk("to rom_cs", {31'b0, rom_cs}, 0);
    chk("to miss_cnt", {24'b0, miss_cnt}, 1);
    chk("to tm_data", tm_data, 32'h11112222);
    chk("to tm_ok", {31'b0, tm_ok}, 0);

    // Address change in WAIT aborts and restarts
    tm_cs = 0; step();
    tm_cs = 1; tm_addr = 15'h0200; step();
    chk("ab first rom_addr", {17'b0, rom_addr}, 32'h0200);
    step();
    tm_addr = 15'h0201; step();
    chk("ab miss", {31'b0, miss}, 1);
    chk("ab rom_addr", {17'b0, rom_addr}, 32'h0201);
    chk("ab rom_cs", {31'b0, rom_cs}, 1);
    chk("ab miss_cnt", {24'b0, miss_cnt}, 2);
    step();
    chk("ab miss one clk", {31'b0, miss}, 0);
    chk("ab rom_cs held", {31'b0, rom_cs}, 1);
    rom_ok = 1; rom_data = 32'h02010201; step();
    rom_ok = 0;
    chk("ab tm_data", tm_data, 32'h02010201);
    chk("ab tm_ok", {31'b0, tm_ok}, 1);
    chk("ab miss_cnt after", {24'b0, miss_cnt}, 2);

    // Blanking mid-WAIT, then refetch of the same address
    tm_addr = 15'h0300; step(); step();
    tm_cs = 0; step();
    chk("bl rom_cs", {31'b0, rom_cs}, 0);
    chk("bl miss", {31'b0, miss}, 0);
    chk("bl tm_data", tm_data, 32'h02010201);
    step();
    tm_cs = 1; step();
    chk("bl refetch cs", {31'b0, rom_cs}, 1);
    chk("bl refetch addr", {17'b0, rom_addr}, 32'h0300);
    rom_ok = 1; rom_data = 32'h03030303; step(); step();
    rom_ok = 0;
    chk("bl tm_data new", tm_data, 32'h03030303);
    chk("bl miss_cnt", {24'b0, miss_cnt}, 2);

    // Reset in WAIT with ok in the same clk
    tm_addr = 15'h0500; step(); step();
    rst = 1; rom_ok = 1; rom_data = 32'hFFFFFFFF; step();
    chk("rw rom_cs", {31'b0, rom_cs}, 0);
    chk("rw rom_addr", {17'b0, rom_addr}, 0);
    chk("rw tm_data", tm_data, 0);
    chk("rw tm_ok", {31'b0, tm_ok}, 0);
    chk("rw miss_cnt", {24'b0, miss_cnt}, 0);
    rst = 0; rom_ok = 0; tm_cs = 0; step();

    // Five timeouts: 2-bit counter saturates
    tm_cs = 1; pxl_cen = 1;
    for (int i = 0; i < 5; i++) begin
      tm_addr = 15'h0400 + 15'(i);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        step();
        if (miss) seen = 1;
      end
      chk($sformatf("sat%0d seen", i), {31'b0, seen}, 1);
      chk($sformatf("sat%0d cnt2", i), {30'b0, miss_cnt2}, {30'b0, exp_sat[i]});
      chk($sformatf("sat%0d cnt8", i), {24'b0, miss_cnt}, i + 1);
    end
    pxl_cen = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
